// File: rtl/stm_focus_writer_pkg.sv
// Shared widths, field offsets and the STM focus word layout used by writer and reader.
package stm_focus_writer_pkg;

    localparam int unsigned NumFociMax      = 8;
    localparam int unsigned FociWidth       = 3;
    localparam int unsigned PointWidth      = 13;
    localparam int unsigned CycleWidth      = 14;
    localparam int unsigned NumFociWidth    = 4;
    localparam int unsigned AddrWidth       = PointWidth + FociWidth;
    localparam int unsigned BramAddrWidth   = AddrWidth + 1;
    localparam int unsigned CoordWidth      = 18;
    localparam int unsigned IntensityWidth  = 8;
    localparam int unsigned WordWidth       = 64;

    localparam int unsigned FocusXLsb         = 0;
    localparam int unsigned FocusYLsb         = FocusXLsb + CoordWidth;
    localparam int unsigned FocusZLsb         = FocusYLsb + CoordWidth;
    localparam int unsigned FocusIntensityLsb = FocusZLsb + CoordWidth;

    typedef struct packed {
        logic [1:0]                pad;
        logic [IntensityWidth-1:0] intensity;
        logic [CoordWidth-1:0]     z;
        logic [CoordWidth-1:0]     y;
        logic [CoordWidth-1:0]     x;
    } stm_focus_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2
    } wr_state_e;

endpackage

// File: rtl/stm_focus_pack.sv
// Combinational packing of one focus into the STM BRAM word layout.
module stm_focus_pack
    import stm_focus_writer_pkg::*;
(
    input  logic [CoordWidth-1:0]     x_i,
    input  logic [CoordWidth-1:0]     y_i,
    input  logic [CoordWidth-1:0]     z_i,
    input  logic [IntensityWidth-1:0] intensity_i,
    output stm_focus_word_t           word_c_o
);

    // Coordinates pass through untouched in two's complement; top bits are zero fill.
    always_comb begin
        word_c_o           = '0;
        word_c_o.pad       = 2'b00;
        word_c_o.intensity = intensity_i;
        word_c_o.z         = z_i;
        word_c_o.y         = y_i;
        word_c_o.x         = x_i;
    end

endmodule

// File: rtl/stm_focus_writer.sv
// Streaming writer filling one STM focus segment: one focus per beat, one BRAM write per focus.
module stm_focus_writer
    import stm_focus_writer_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic                      segment_i,
    input  logic [CycleWidth-1:0]     cycle_i,
    input  logic [NumFociWidth-1:0]   num_foci_i,
    input  logic                      din_valid_i,
    output logic                      din_ready_o,
    input  logic [CoordWidth-1:0]     x_i,
    input  logic [CoordWidth-1:0]     y_i,
    input  logic [CoordWidth-1:0]     z_i,
    input  logic [IntensityWidth-1:0] intensity_i,
    output logic                      bram_we_o,
    output logic [BramAddrWidth-1:0]  bram_addr_o,
    output logic [WordWidth-1:0]      bram_din_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    wr_state_e                  state_q, state_d;
    logic                       seg_q, seg_d;
    logic [PointWidth-1:0]      cycle_q, cycle_d;
    logic [NumFociWidth-1:0]    nf_q, nf_d;
    logic [PointWidth-1:0]      pt_q, pt_d;
    logic [FociWidth-1:0]       f_q, f_d;
    logic                       ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic                       we_q, we_d;
    logic [BramAddrWidth-1:0]   addr_q, addr_d;
    logic [WordWidth-1:0]       din_q, din_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;

    stm_focus_word_t            word_c;
    logic                       accept_c;
    logic                       f_last_c;
    logic                       last_c;
    logic                       cfg_ok_c;

    stm_focus_pack u_pack (
        .x_i         (x_i),
        .y_i         (y_i),
        .z_i         (z_i),
        .intensity_i (intensity_i),
        .word_c_o    (word_c)
    );

    // Handshake, counter wrap and START validity decode.
    always_comb begin
        accept_c = (state_q == ST_FILL) && din_valid_i;
        f_last_c = ({1'b0, f_q} == (nf_q - NumFociWidth'(1)));
        last_c   = f_last_c && (pt_q == cycle_q);
        cfg_ok_c = (num_foci_i != '0)
                && (num_foci_i <= NumFociWidth'(NumFociMax))
                && (cycle_i < CycleWidth'(1 << PointWidth));
    end

    // Next-state: FSM, counters, write port and status pulses.
    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        cycle_d = cycle_q;
        nf_d    = nf_q;
        pt_d    = pt_q;
        f_d     = f_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (accept_c) begin
            we_d   = 1'b1;
            addr_d = {seg_q, pt_q, f_q};
            din_d  = word_c;
            if (f_last_c) begin
                f_d  = '0;
                pt_d = pt_q + PointWidth'(1);
            end else begin
                f_d  = f_q + FociWidth'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    if (cfg_ok_c) begin
                        state_d = ST_FILL;
                        seg_d   = segment_i;
                        cycle_d = PointWidth'(cycle_i);
                        nf_d    = num_foci_i;
                        pt_d    = '0;
                        f_d     = '0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (accept_c && last_c) begin
                    state_d = ST_FLUSH;
                    done_d  = 1'b1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_FILL);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seg_q   <= 1'b0;
            cycle_q <= '0;
            nf_q    <= '0;
            pt_q    <= '0;
            f_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            cycle_q <= cycle_d;
            nf_q    <= nf_d;
            pt_q    <= pt_d;
            f_q     <= f_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign din_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign bram_we_o   = we_q;
    assign bram_addr_o = addr_q;
    assign bram_din_o  = din_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_stm_focus_writer.sv
// Directed bench for stm_focus_writer: fills, gaps, packing boundary, rejects, abort, reset.
module tb_stm_focus_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        segment_i = 1'b0;
    logic [13:0] cycle_i = '0;
    logic [3:0]  num_foci_i = '0;
    logic        din_valid_i = 1'b0;
    logic        din_ready_o;
    logic [17:0] x_i = '0;
    logic [17:0] y_i = '0;
    logic [17:0] z_i = '0;
    logic [7:0]  intensity_i = '0;
    logic        bram_we_o;
    logic [16:0] bram_addr_o;
    logic [63:0] bram_din_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    int n_done = 0;
    logic [16:0] done_addr;
    logic [63:0] last_din;

    logic [16:0] exp_addr_q[$];
    logic [63:0] exp_din_q[$];

    always #5 clk = ~clk;

    stm_focus_writer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .segment_i   (segment_i),
        .cycle_i     (cycle_i),
        .num_foci_i  (num_foci_i),
        .din_valid_i (din_valid_i),
        .din_ready_o (din_ready_o),
        .x_i         (x_i),
        .y_i         (y_i),
        .z_i         (z_i),
        .intensity_i (intensity_i),
        .bram_we_o   (bram_we_o),
        .bram_addr_o (bram_addr_o),
        .bram_din_o  (bram_din_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every BRAM write must match the next expected word.
    always @(negedge clk) begin
        if (rst_n && bram_we_o) begin
            n_writes++;
            last_din = bram_din_o;
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_write", {47'd0, bram_addr_o}, 64'h1ffff);
            end else begin
                chk("wr_addr", {47'd0, bram_addr_o}, {47'd0, exp_addr_q.pop_front()});
                chk("wr_din", bram_din_o, exp_din_q.pop_front());
            end
        end
        if (rst_n && done_o) begin
            n_done++;
            done_addr = bram_addr_o;
            chk("done_with_we", {63'd0, bram_we_o}, 64'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic seg, input logic [13:0] cyc, input logic [3:0] nf);
        start_i = 1'b1;
        segment_i = seg;
        cycle_i = cyc;
        num_foci_i = nf;
        tick();
        start_i = 1'b0;
    endtask

    // Feed n beats; the bench tracks point/focus itself to predict each address.
    task automatic feed(input int n, input bit gaps, input logic seg, input int nf,
                        input bit fixed, output int cycles);
        int sent = 0;
        int pt = 0;
        int f = 0;
        cycles = 0;
        while (sent < n && cycles < 400) begin
            din_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!fixed) begin
                x_i = 18'($urandom);
                y_i = 18'($urandom);
                z_i = 18'($urandom);
                intensity_i = 8'($urandom);
            end
            if (din_valid_i && din_ready_o) begin
                exp_addr_q.push_back({seg, 13'(pt), 3'(f)});
                exp_din_q.push_back({2'b00, intensity_i, z_i, y_i, x_i});
                sent++;
                if (f == nf - 1) begin
                    f = 0;
                    pt++;
                end else begin
                    f++;
                end
            end
            tick();
            cycles++;
        end
        din_valid_i = 1'b0;
        if (sent < n) chk("feed_timeout", 64'(sent), 64'(n));
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy_o && k < 100) begin
            tick();
            k++;
        end
        if (busy_o) chk("idle_timeout", {63'd0, busy_o}, 64'd0);
        tick();
    endtask

    int w0, d0, cyc;

    initial begin
        // Reset state
        #12;
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_ready", {63'd0, din_ready_o}, 64'd0);
        chk("rst_we", {63'd0, bram_we_o}, 64'd0);
        chk("rst_addr", {47'd0, bram_addr_o}, 64'd0);
        chk("rst_din", bram_din_o, 64'd0);
        chk("rst_done_err", {62'd0, done_o, err_o}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back fill, one focus per point
        w0 = n_writes; d0 = n_done;
        start_fill(1'b0, 14'd15, 4'd1);
        chk("fill_ready", {63'd0, din_ready_o}, 64'd1);
        feed(16, 1'b0, 1'b0, 1, 1'b0, cyc);
        chk("b2b_cycles", 64'(cyc), 64'd16);
        wait_idle();
        chk("b2b_writes", 64'(n_writes - w0), 64'd16);
        chk("b2b_done", 64'(n_done - d0), 64'd1);
        chk("b2b_done_addr", {47'd0, done_addr}, 64'd120);
        chk("b2b_pending", 64'(exp_addr_q.size()), 64'd0);

        // Multi-foci with random gaps
        w0 = n_writes; d0 = n_done;
        start_fill(1'b1, 14'd3, 4'd3);
        feed(12, 1'b1, 1'b1, 3, 1'b0, cyc);
        wait_idle();
        chk("mf_writes", 64'(n_writes - w0), 64'd12);
        chk("mf_done", 64'(n_done - d0), 64'd1);
        chk("mf_done_addr", {47'd0, done_addr}, 64'h1001a);
        chk("mf_pending", 64'(exp_addr_q.size()), 64'd0);

        // Field boundary packing
        x_i = 18'h20000; y_i = 18'h1ffff; z_i = 18'h3ffff; intensity_i = 8'hff;
        start_fill(1'b0, 14'd0, 4'd1);
        feed(1, 1'b0, 1'b0, 1, 1'b1, cyc);
        wait_idle();
        chk("pack_boundary", last_din, 64'h3fff_fff7_fffe_0000);

        // Rejected STARTs
        w0 = n_writes;
        start_fill(1'b0, 14'd15, 4'd0);
        chk("rej0_err", {63'd0, err_o}, 64'd1);
        chk("rej0_busy", {63'd0, busy_o}, 64'd0);
        tick();
        chk("rej0_err_pulse", {63'd0, err_o}, 64'd0);
        start_fill(1'b0, 14'd15, 4'd9);
        chk("rej9_err", {63'd0, err_o}, 64'd1);
        chk("rej9_busy", {63'd0, busy_o}, 64'd0);
        start_fill(1'b0, 14'd8192, 4'd1);
        chk("rejcyc_err", {63'd0, err_o}, 64'd1);
        chk("rejcyc_busy", {63'd0, busy_o}, 64'd0);
        tick();
        chk("rej_writes", 64'(n_writes - w0), 64'd0);

        // Abort after 5 of 16 beats, then refill
        w0 = n_writes; d0 = n_done;
        start_fill(1'b0, 14'd15, 4'd1);
        feed(5, 1'b0, 1'b0, 1, 1'b0, cyc);
        abort_i = 1'b1;
        start_i = 1'b1;
        num_foci_i = 4'd0;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abort_busy", {63'd0, busy_o}, 64'd0);
        chk("abort_no_err", {63'd0, err_o}, 64'd0);
        tick();
        chk("abort_writes", 64'(n_writes - w0), 64'd5);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        w0 = n_writes; d0 = n_done;
        start_fill(1'b0, 14'd15, 4'd1);
        feed(16, 1'b0, 1'b0, 1, 1'b0, cyc);
        wait_idle();
        chk("refill_writes", 64'(n_writes - w0), 64'd16);
        chk("refill_done", 64'(n_done - d0), 64'd1);
        chk("refill_done_addr", {47'd0, done_addr}, 64'd120);

        // Async reset mid-fill, then a fresh fill from counter zero
        start_fill(1'b0, 14'd15, 4'd1);
        feed(3, 1'b0, 1'b0, 1, 1'b0, cyc);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_we", {63'd0, bram_we_o}, 64'd0);
        chk("arst_busy", {63'd0, busy_o}, 64'd0);
        chk("arst_ready", {63'd0, din_ready_o}, 64'd0);
        exp_addr_q.delete();
        exp_din_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        w0 = n_writes; d0 = n_done;
        start_fill(1'b1, 14'd0, 4'd2);
        feed(2, 1'b0, 1'b1, 2, 1'b0, cyc);
        wait_idle();
        chk("post_rst_writes", 64'(n_writes - w0), 64'd2);
        chk("post_rst_done_addr", {47'd0, done_addr}, 64'h10001);
        chk("post_rst_pending", 64'(exp_addr_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
